// File: rtl/demux_1_4_sched.sv
// Burst scheduler for a 1:4 demux: picks a destination per burst (addressed or round-robin),
// holds the select for the whole burst and registers each beat in a 1-entry output buffer.
module demux_1_4_sched #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  input  logic              in_last,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              burst_trunc
);

  localparam logic [7:0] BurstMax = 8'(BURST_MAX);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e              state_q, state_d;
  logic                buf_valid_q, buf_valid_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                trunc_q, trunc_d;
  logic                burst_rr_q, burst_rr_d;

  logic                accept;
  logic [7:0]          cnt_inc;
  logic                cnt_hit;

  // The buffer may refill in the same cycle it drains.
  assign in_ready = !buf_valid_q | out_ready[sel_q];
  assign accept   = in_valid & in_ready;
  assign cnt_inc  = beat_cnt_q + 8'd1;
  assign cnt_hit  = (cnt_inc == BurstMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      buf_valid_q <= 1'b0;
      sel_q       <= 2'b00;
      rr_ptr_q    <= 2'b00;
      beat_cnt_q  <= 8'd0;
      data_q      <= '0;
      last_q      <= 1'b0;
      trunc_q     <= 1'b0;
      burst_rr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      data_q      <= data_d;
      last_q      <= last_d;
      trunc_q     <= trunc_d;
      burst_rr_q  <= burst_rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept && !in_last) state_d = StLocked;
      StLocked: if (accept && (in_last || cnt_hit)) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    data_d      = data_q;
    last_d      = last_q;
    trunc_d     = 1'b0;
    burst_rr_d  = burst_rr_q;
    if (accept) begin
      buf_valid_d = 1'b1;
      data_d      = in_data;
      last_d      = in_last;
      beat_cnt_d  = cnt_inc;
      if (state_q == StIdle) begin
        // sel only moves on a first beat, which implies the buffer is empty or draining.
        sel_d      = mode ? rr_ptr_q : in_dest;
        burst_rr_d = mode;
        beat_cnt_d = 8'd1;
        if (in_last && mode) rr_ptr_d = rr_ptr_q + 2'd1;
      end else if (in_last || cnt_hit) begin
        last_d  = 1'b1;
        trunc_d = !in_last;
        if (burst_rr_q) rr_ptr_d = rr_ptr_q + 2'd1;
      end
    end else if (buf_valid_q && out_ready[sel_q]) begin
      buf_valid_d = 1'b0;
    end
  end

  assign sel         = sel_q;
  assign out_data    = data_q;
  assign out_last    = last_q;
  assign out_valid   = buf_valid_q ? (4'b0001 << sel_q) : 4'b0000;
  assign busy        = (state_q == StLocked);
  assign burst_trunc = trunc_q;

endmodule

// File: doc/demux_1_4_sched.md
Name: demux_1_4_sched

Overview:
- Burst scheduler and controller for the 1:4 demultiplexer datapath.
- Accepts a single valid/ready input stream and decides which of four destinations each burst goes to. Selection is either by address (in_dest) or round-robin.
- Holds the demux select stable for the whole burst and registers the beat in a 1-entry output buffer.
- Sits between the upstream producer and the demux select/data lines; exposes per-destination valid/ready.

Parameters:
- DATA_W, 8, width of the data beat.
- BURST_MAX, 16, maximum beats per burst before forced termination (2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- mode  in  1  0 = addressed (use in_dest), 1 = round-robin. Sampled only at burst start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  DATA_W  input beat payload.
- in_dest  in  2  destination index. Sampled only at the first beat of a burst.
- in_last  in  1  final beat of the burst.
- sel  out  2  demux select for the buffered beat.
- out_data  out  DATA_W  buffered payload, common to all four outputs.
- out_valid  out  4  one-hot valid; bit sel set when the buffer is full.
- out_ready  in  4  per-destination ready.
- out_last  out  1  buffered beat ends its burst.
- busy  out  1  high while in state LOCKED.
- burst_trunc  out  1  one-cycle pulse when a burst is cut at BURST_MAX.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; buf_valid 0; sel 2'b00; rr_ptr 2'b00; beat_cnt 0.
  - out_data 0; out_last 0; out_valid 4'b0000; busy 0; burst_trunc 0.
- Handshakes:
  - in_ready = !buf_valid | out_ready[sel] (combinational; buffer can refill in the same cycle it drains).
  - Accept = in_valid & in_ready.
  - Output transfer = out_valid[sel] & out_ready[sel].
  - out_valid = buf_valid ? (4'b0001 << sel) : 4'b0000.
- Latency: accepted beat appears on out_data/out_valid the next cycle. Full throughput: 1 beat/cycle while the destination is ready.
- FSM:
  - IDLE: on accept, dest = mode ? rr_ptr : in_dest. Load sel = dest and load buffer, beat_cnt = 1.
    - If in_last: stay IDLE; out_last = 1; if mode == 1, rr_ptr += 1.
    - Else: go to LOCKED.
  - LOCKED: sel frozen; in_dest and mode ignored. Each accept loads the buffer, beat_cnt += 1.
    - Accept with in_last: out_last = 1, go to IDLE, rr_ptr += 1 (if burst was RR).
    - Accept where beat_cnt reaches BURST_MAX without in_last: treat the beat as last (out_last = 1), pulse burst_trunc, go to IDLE. Following beats start a new burst and re-sample dest.
- sel update rule: sel changes only when loading the first beat of a burst, and only when the buffer is empty or draining that cycle. A new burst to a different destination therefore never changes sel while an old beat is pending.
- rr_ptr wraps 3 -> 0. It advances only at burst end in round-robin mode, never in addressed mode.
- Backpressure: while out_ready[sel] = 0 and buf_valid = 1, the buffer and sel hold; in_ready = 0. Ready bits of non-selected destinations have no effect.
- Simultaneous drain + accept: the buffer is overwritten with the new beat; buf_valid stays 1.
- busy = (state == LOCKED).
- Reset mid-burst: all state clears immediately; any partial burst is discarded; the next beat is treated as a first beat.
- in_last on a BURST_MAX-th beat: normal end; no burst_trunc.

Test Plan:
1. Reset with in_valid = 1: out_valid = 0000, sel = 00, in_ready = 1, busy = 0. After release, accept in_data = 8'hA5, dest = 2, last, mode 0 → next cycle out_valid = 0100, sel = 10, out_data = A5, out_last = 1.
2. Addressed burst, 3 beats to dest 1 with in_dest toggling to 3 mid-burst; out_ready = 1111 → sel stays 01 for all 3 beats; busy high for beats 2-3; back-to-back, one beat per cycle.
3. Round-robin, four 1-beat bursts → sel sequence 00, 01, 10, 11, then 00 on the fifth. Switching to mode 0 mid-burst has no effect until IDLE.
4. Backpressure: dest 3 burst, drop out_ready[3] for 4 cycles while out_ready[0..2] = 1 → in_ready = 0, out_data held, no beat lost or duplicated. Scoreboard matches beats.
5. BURST_MAX = 4, send 6 beats with in_last only on beat 6 → burst_trunc pulses on beat 4 acceptance. Beats 5-6 form a new burst with a re-sampled dest.
6. Assert rst_n low in LOCKED with the buffer full → outputs zero asynchronously. After release, a new 1-beat burst routes correctly.
